// File: rtl/da_pkg.sv
// Shared types and width helpers for the serial distributed-arithmetic FIR sequencer.
package da_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  // Address width of the 16-entry DA table (one bit per tap).
  localparam int ADDR_W = 4;

  function automatic int out_width(input int w, input int cw);
    return w + cw + 2;
  endfunction

endpackage

// File: rtl/da_serial_ctrl_if.sv
// Sample-in / result-out valid-ready bundle for the serial DA FIR sequencer.
interface da_serial_ctrl_if
  import da_pkg::*;
#(
  parameter int W     = 4,
  parameter int OUT_W = out_width(4, 4)
);

  logic signed [W-1:0]     x_in;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [OUT_W-1:0] y;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output x_in, in_valid, out_ready,
    input  in_ready, y, out_valid
  );

  modport slave (
    input  x_in, in_valid, out_ready,
    output in_ready, y, out_valid
  );

endinterface

// File: rtl/da_lut4.sv
// 16-entry DA table: each address bit selects one coefficient, the entry is their
// sign-extended sum, so the table is realised as a masked adder rather than a ROM.
module da_lut4
  import da_pkg::*;
#(
  parameter int CW    = 4,
  parameter int OUT_W = 10
) (
  input  logic        [ADDR_W-1:0] addr,
  input  logic signed [CW-1:0]     c0,
  input  logic signed [CW-1:0]     c1,
  input  logic signed [CW-1:0]     c2,
  input  logic signed [CW-1:0]     c3,
  output logic signed [OUT_W-1:0]  sum
);

  function automatic logic signed [OUT_W-1:0] sext(input logic signed [CW-1:0] c);
    return {{(OUT_W-CW){c[CW-1]}}, c};
  endfunction

  always_comb begin
    sum = '0;
    if (addr[0]) sum = sum + sext(c0);
    if (addr[1]) sum = sum + sext(c1);
    if (addr[2]) sum = sum + sext(c2);
    if (addr[3]) sum = sum + sext(c3);
  end

endmodule

// File: rtl/da_serial_ctrl.sv
// Bit-serial 4-tap DA FIR sequencer: one sample in, W LSB-first bit-plane accumulates, one result out.
// Define DA_COEF_LOAD_EN to make the coefficients run-time writable (cfg_* ports, IDLE only).
module da_serial_ctrl
  import da_pkg::*;
#(
  parameter int W     = 4,
  parameter int CW    = 4,
  parameter int C0    = 2,
  parameter int C1    = 3,
  parameter int C2    = 1,
  parameter int C3    = -1,
  parameter int OUT_W = out_width(W, CW)
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef DA_COEF_LOAD_EN
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_addr,
  input  logic signed [CW-1:0] cfg_data,
`endif
  da_serial_ctrl_if.slave      bus
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_t                  state;
  logic signed [W-1:0]     taps [4];
  logic [CNT_W-1:0]        cnt;
  logic signed [OUT_W-1:0] acc;
  logic signed [OUT_W-1:0] y_r;
  logic                    out_valid_r;
  logic signed [CW-1:0]    coef [4];

  logic [ADDR_W-1:0]       addr;
  logic signed [OUT_W-1:0] lut;
  logic signed [OUT_W-1:0] plane;
  logic signed [OUT_W-1:0] acc_next;

`ifdef DA_COEF_LOAD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coef[0] <= CW'(C0);
      coef[1] <= CW'(C1);
      coef[2] <= CW'(C2);
      coef[3] <= CW'(C3);
    end else if (cfg_we && state == IDLE) begin
      coef[cfg_addr] <= cfg_data;
    end
  end
`else
  assign coef[0] = CW'(C0);
  assign coef[1] = CW'(C1);
  assign coef[2] = CW'(C2);
  assign coef[3] = CW'(C3);
`endif

  always_comb begin
    addr = {taps[3][cnt], taps[2][cnt], taps[1][cnt], taps[0][cnt]};
  end

  da_lut4 #(.CW(CW), .OUT_W(OUT_W)) u_lut (
    .addr (addr),
    .c0   (coef[0]),
    .c1   (coef[1]),
    .c2   (coef[2]),
    .c3   (coef[3]),
    .sum  (lut)
  );

  // The MSB plane carries negative weight in two's complement, hence the subtract.
  always_comb begin
    plane    = lut <<< cnt;
    acc_next = (cnt == CNT_LAST) ? acc - plane : acc + plane;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      for (int k = 0; k < 4; k++) taps[k] <= '0;
      cnt         <= '0;
      acc         <= '0;
      y_r         <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            taps[0] <= bus.x_in;
            taps[1] <= taps[0];
            taps[2] <= taps[1];
            taps[3] <= taps[2];
            acc     <= '0;
            cnt     <= '0;
            state   <= ACC;
          end
        end
        ACC: begin
          acc <= acc_next;
          if (cnt == CNT_LAST) begin
            y_r         <= acc_next;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !reset;
  assign bus.y         = y_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_da_serial_ctrl.sv
// Bench for da_serial_ctrl: directed cases plus random samples against a direct-convolution model.
module tb_da_serial_ctrl;
  import da_pkg::*;

  localparam int W     = 4;
  localparam int CW    = 4;
  localparam int OUT_W = out_width(W, CW);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  da_serial_ctrl_if #(.W(W), .OUT_W(OUT_W)) bus ();

`ifdef DA_COEF_LOAD_EN
  logic                 cfg_we   = 1'b0;
  logic [1:0]           cfg_addr = '0;
  logic signed [CW-1:0] cfg_data = '0;
`endif

  da_serial_ctrl #(
    .W(W), .CW(CW), .C0(2), .C1(3), .C2(1), .C3(-1), .OUT_W(OUT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef DA_COEF_LOAD_EN
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
`endif
    .bus      (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  int hist [4];
  int coef [4] = '{2, 3, 1, -1};
  int exp_q [$];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, expv);
    end
  endtask

  // Reference: y[n] = sum_k coef[k] * x[n-k] over the accepted samples.
  function automatic void model_accept(input int x);
    int s;
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = x;
    s = 0;
    for (int k = 0; k < 4; k++) s += coef[k] * hist[k];
    exp_q.push_back(s);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) hist[k] = 0;
    exp_q.delete();
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int x);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.x_in     = W'(x);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("send_ready", bus.in_ready, 1);
    if (bus.in_ready) begin
      @(posedge clk);
      model_accept(x);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.x_in     = W'($urandom);
  endtask

  task automatic drain(input int stall, input string tag);
    int waited;
    int expv;
    waited = 0;
    while (!bus.out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_valid"}, bus.out_valid, 1);
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    check(tag, bus.y, expv);
    if (bus.out_valid) begin
      bus.out_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check({tag, "_hold_y"}, bus.y, expv);
        check({tag, "_hold_v"}, bus.out_valid, 1);
        check({tag, "_hold_rdy"}, bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, "_ack"}, bus.out_valid, 0);
      check({tag, "_idle"}, bus.in_ready, 1);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w;
    int expv;
    int x;

    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.out_ready = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_y", bus.y, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);

    // Impulse response walks out the coefficients, then returns to zero.
    send(1);  drain(0, "imp0");
    for (int i = 0; i < 4; i++) begin
      send(0); drain(0, "imp");
    end

    // Negative full scale exercises the sign-plane subtraction.
    send(-8); drain(0, "neg0");
    for (int i = 0; i < 3; i++) begin
      send(0); drain(1, "neg");
    end

    // Latency counted in edges, accepting edge included.
    send(3);
    n = 1;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency", n, 5);
    drain(0, "lat");

    // Backpressure: result held, new samples refused while stalled.
    send(2);
    w = 0;
    while (!bus.out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    bus.in_valid = 1'b1;
    bus.x_in     = W'(5);
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_y", bus.y, expv);
      check("bp_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_release_rdy", bus.in_ready, 1);
    check("bp_release_v", bus.out_valid, 0);
    send(0); drain(0, "bp_after");

    // Steady input from cleared taps.
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      send(7); drain(0, "steady");
    end

    // Reset during ACC at cnt = 2 drops the result and the taps.
    send(1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_valid", bus.out_valid, 0);
    check("abort_y", bus.y, 0);
    check("abort_in_ready", bus.in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    send(1); drain(0, "post_abort0");
    send(0); drain(0, "post_abort1");

    // Random samples with random backpressure and idle gaps.
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.out_ready = 1'($urandom_range(0, 1));
      x = int'($urandom_range(0, 15)) - 8;
      send(x);
      drain(int'($urandom_range(0, 3)), "rnd");
    end

`ifdef DA_COEF_LOAD_EN
    // IDLE write lands, ACC write is dropped.
    pulse_reset();
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 4'sd5;
    @(negedge clk);
    cfg_we = 1'b0;
    coef[1] = 5;
    send(1);
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 4'sd7;
    @(negedge clk);
    cfg_we = 1'b0;
    drain(0, "cfg0");
    for (int i = 0; i < 3; i++) begin
      send(0); drain(0, "cfg");
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
